// File: rtl/keccak_pkg.sv
// keccak_pkg: shared definitions for the Keccak absorb/squeeze controller.
//   - state_t  : controller FSM states
//   - NROUNDS  : Keccak-f[1600] round count
//   - MODE_*   : cmode encodings (SHA3-224/256/384/512, SHAKE128/256)
//   - rate_of  : rate table, in bytes per block, for each mode
package keccak_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_PERMUTE = 3'd2,
    ST_RELEASE = 3'd3,
    ST_SQUEEZE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int unsigned NROUNDS    = 24;
  localparam logic [4:0]  LAST_ROUND = 5'(NROUNDS - 1);

  localparam logic [2:0] MODE_SHA3_224 = 3'd0;
  localparam logic [2:0] MODE_SHA3_256 = 3'd1;
  localparam logic [2:0] MODE_SHA3_384 = 3'd2;
  localparam logic [2:0] MODE_SHA3_512 = 3'd3;
  localparam logic [2:0] MODE_SHAKE128 = 3'd4;
  localparam logic [2:0] MODE_SHAKE256 = 3'd5;

  // Rate table; illegal modes read as 0.
  function automatic logic [7:0] rate_of(input logic [2:0] mode);
    logic [7:0] r;
    case (mode)
      MODE_SHA3_224: r = 8'd144;
      MODE_SHA3_256: r = 8'd136;
      MODE_SHA3_384: r = 8'd104;
      MODE_SHA3_512: r = 8'd72;
      MODE_SHAKE128: r = 8'd168;
      MODE_SHAKE256: r = 8'd136;
      default:       r = 8'd0;
    endcase
    return r;
  endfunction

  function automatic logic mode_legal(input logic [2:0] mode);
    return (mode <= MODE_SHAKE256);
  endfunction

  function automatic logic mode_is_shake(input logic [2:0] mode);
    return (mode == MODE_SHAKE128) || (mode == MODE_SHAKE256);
  endfunction

endpackage

// File: rtl/keccak_round_cnt.sv
// keccak_round_cnt: round index counter for one Keccak-f permutation.
//   clk, rst  : clock, synchronous active-high reset
//   start     : a permutation begins next cycle; forces index to 0
//   run       : permutation is active this cycle
//   round_idx : current round 0..NROUNDS-1 (0 when idle)
//   last      : run is high and this is the final round
module keccak_round_cnt
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  output logic [4:0] round_idx,
  output logic       last
);

  logic [4:0] idx_r;

  assign round_idx = idx_r;
  assign last      = run && (idx_r == LAST_ROUND);

  // Round index: advances while running, wraps to 0 after the last round.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= 5'd0;
    end else if (start) begin
      idx_r <= 5'd0;
    end else if (run && !last) begin
      idx_r <= idx_r + 5'd1;
    end else begin
      idx_r <= 5'd0;
    end
  end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// keccak_absorb_ctrl: sequences absorb, permutation and squeeze for a
// Keccak-based hash (SHA3-224/256/384/512, SHAKE128/256).
//   clk, rst   : clock, synchronous active-high reset
//   cmode      : hash mode, latched when a block is accepted
//   buff_full  : input buffer holds a full padded rate block
//   first      : buffered block is the first of the message
//   last_i     : pulse, final message word entered the buffer
//   sq_blocks  : SHAKE output block count (0 means 1)
//   dout_ready : sink accepts the current output block
//   en_counter : buffer hold (ABSORB/PERMUTE)
//   state_load : XOR buffer into the state
//   state_clr  : zero the state before the XOR (first block)
//   round_en   : permutation round active, round_idx = round number
//   rate_bytes : rate of the latched mode
//   dout_valid : output block available
//   done       : message complete pulse
//   busy       : FSM not idle
//   err        : pulse, block offered with an illegal mode
module keccak_absorb_ctrl
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cmode,
  input  logic       buff_full,
  input  logic       first,
  input  logic       last_i,
  input  logic [7:0] sq_blocks,
  input  logic       dout_ready,
  output logic       en_counter,
  output logic       state_load,
  output logic       state_clr,
  output logic       round_en,
  output logic [4:0] round_idx,
  output logic [7:0] rate_bytes,
  output logic       dout_valid,
  output logic       done,
  output logic       busy,
  output logic       err
);

  state_t     state_r, state_nx;
  logic [2:0] cmode_r;
  logic       first_r;
  logic [7:0] sq_cnt_r;
  logic [7:0] sq_limit_r;
  logic       pending_last_r;
  logic       err_r;

  logic       accept_s;
  logic       legal_s;
  logic       handshake_s;
  logic       round_last_s;
  logic       round_start_s;
  logic [7:0] sq_blocks_eff_s;
  logic [7:0] sq_cnt_inc_s;
  logic [7:0] sq_limit_s;
  logic       limit_hit_s;

  assign accept_s    = (state_r == ST_IDLE) && buff_full;
  assign legal_s     = mode_legal(cmode);
  assign handshake_s = (state_r == ST_SQUEEZE) && dout_ready;

  assign sq_blocks_eff_s = (sq_blocks == 8'd0) ? 8'd1 : sq_blocks;
  assign sq_cnt_inc_s    = (sq_cnt_r == 8'hFF) ? 8'hFF : (sq_cnt_r + 8'd1);
  // The SHAKE limit is taken live on the first handshake and held afterwards.
  assign sq_limit_s  = !mode_is_shake(cmode_r) ? 8'd1 :
                       (sq_cnt_r == 8'd0) ? sq_blocks_eff_s : sq_limit_r;
  assign limit_hit_s = (sq_cnt_inc_s >= sq_limit_s);

  assign round_start_s = (state_nx == ST_PERMUTE) && (state_r != ST_PERMUTE);

  keccak_round_cnt u_round_cnt (
    .clk       (clk),
    .rst       (rst),
    .start     (round_start_s),
    .run       (state_r == ST_PERMUTE),
    .round_idx (round_idx),
    .last      (round_last_s)
  );

  assign rate_bytes = rate_of(cmode_r);
  assign err        = err_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // FSM next state and state-decoded outputs.
  always_comb begin
    state_nx   = state_r;
    en_counter = 1'b0;
    state_load = 1'b0;
    state_clr  = 1'b0;
    round_en   = 1'b0;
    dout_valid = 1'b0;
    done       = 1'b0;
    busy       = (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nx = legal_s ? ST_ABSORB : ST_RELEASE;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ABSORB: begin
        en_counter = 1'b1;
        state_load = 1'b1;
        state_clr  = first_r;
        state_nx   = ST_PERMUTE;
      end
      ST_PERMUTE: begin
        en_counter = 1'b1;
        round_en   = 1'b1;
        if (round_last_s) begin
          state_nx = pending_last_r ? ST_SQUEEZE : ST_RELEASE;
        end else begin
          state_nx = ST_PERMUTE;
        end
      end
      ST_RELEASE: begin
        state_nx = ST_IDLE;
      end
      ST_SQUEEZE: begin
        dout_valid = 1'b1;
        if (handshake_s) begin
          state_nx = limit_hit_s ? ST_DONE : ST_PERMUTE;
        end else begin
          state_nx = ST_SQUEEZE;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_RELEASE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Mode/first latch, squeeze counting, pending-last flag and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmode_r        <= 3'd0;
      first_r        <= 1'b0;
      sq_cnt_r       <= 8'd0;
      sq_limit_r     <= 8'd0;
      pending_last_r <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      err_r <= accept_s && !legal_s;
      if (accept_s && legal_s) begin
        cmode_r <= cmode;
        first_r <= first;
        if (first) begin
          sq_cnt_r <= 8'd0;
        end
      end else if (handshake_s) begin
        sq_cnt_r <= sq_cnt_inc_s;
        if (sq_cnt_r == 8'd0) begin
          sq_limit_r <= sq_blocks_eff_s;
        end
      end
      // A new last_i wins over the clear so a late final word is not lost.
      if (last_i) begin
        pending_last_r <= 1'b1;
      end else if ((state_nx == ST_DONE) && (state_r != ST_DONE)) begin
        pending_last_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Scoreboard bench for keccak_absorb_ctrl: stimulus pushes expected events
// (cycle + data) into a queue, a negedge monitor pops and compares them.
module tb_keccak_absorb_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] cmode;
  logic       buff_full, first, last_i, dout_ready;
  logic [7:0] sq_blocks;
  logic       en_counter, state_load, state_clr, round_en;
  logic [4:0] round_idx;
  logic [7:0] rate_bytes;
  logic       dout_valid, done, busy, err;

  keccak_absorb_ctrl dut (
    .clk(clk), .rst(rst), .cmode(cmode), .buff_full(buff_full),
    .first(first), .last_i(last_i), .sq_blocks(sq_blocks),
    .dout_ready(dout_ready), .en_counter(en_counter),
    .state_load(state_load), .state_clr(state_clr), .round_en(round_en),
    .round_idx(round_idx), .rate_bytes(rate_bytes),
    .dout_valid(dout_valid), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  localparam int EV_LOAD = 1, EV_R0 = 2, EV_R23 = 3, EV_OUT = 4,
                 EV_DONE = 5, EV_ERR = 6;

  typedef struct { int kind; int cyc; int d; } ev_t;
  ev_t q[$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int round_seen = 0;
  int exp_rounds = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int t, input int d);
    ev_t e;
    e.kind = k; e.cyc = t; e.d = d;
    q.push_back(e);
  endtask

  // load event data: {en_counter, state_clr, rate_bytes}
  function automatic int ld(input int clr, input int rate);
    return (1 << 9) | (clr << 8) | rate;
  endfunction

  task automatic match(input int k, input int d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event actual kind=%0d cyc=%0d data=%0h required none", k, cyc, d);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.cyc != cyc || e.d != d) begin
        failures++;
        $display("FAIL event actual kind=%0d cyc=%0d data=%0h required kind=%0d cyc=%0d data=%0h",
                 k, cyc, d, e.kind, e.cyc, e.d);
      end
    end
  endtask

  // Monitor: DUT outputs and inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (round_en) round_seen++;
    if (state_load) match(EV_LOAD, int'({6'd0, en_counter, state_clr, rate_bytes}));
    if (round_en && round_idx == 5'd0) match(EV_R0, int'({en_counter, busy}));
    if (round_en && round_idx == 5'd23) match(EV_R23, int'({en_counter, busy}));
    if (dout_valid && dout_ready) match(EV_OUT, int'(rate_bytes));
    if (done) match(EV_DONE, int'({dout_valid, en_counter}));
    if (err) match(EV_ERR, int'({round_en, state_load}));
  end

  // Advance to 1 ns after the rising edge that starts cycle t.
  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int outs();
    return int'({en_counter, state_load, state_clr, round_en, round_idx,
                 dout_valid, done, busy, err});
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, c2;
    rst = 1'b1; cmode = 3'd0; buff_full = 1'b0; first = 1'b0;
    last_i = 1'b0; sq_blocks = 8'd0; dout_ready = 1'b0;
    @(posedge clk); #1;
    go(cyc + 2);
    chk("reset_outputs", outs(), 0);
    chk("reset_rate", int'(rate_bytes), 144);
    rst = 1'b0;
    go(cyc + 1);

    // SHA3-256 single block
    c = cyc;
    push(EV_LOAD, c + 1, ld(1, 136)); push(EV_R0, c + 2, 3);
    push(EV_R23, c + 25, 3); push(EV_OUT, c + 26, 136); push(EV_DONE, c + 27, 0);
    exp_rounds += 24;
    cmode = 3'd1; first = 1'b1; last_i = 1'b1; buff_full = 1'b1; dout_ready = 1'b1;
    go(c + 1); last_i = 1'b0;
    go(c + 28);
    chk("t1_release_en_counter", int'(en_counter), 0);
    chk("t1_release_busy", int'(busy), 1);
    buff_full = 1'b0;
    go(c + 29);
    chk("t1_idle_busy", int'(busy), 0);
    go(c + 30);

    // SHAKE128, three output blocks, back-pressure, late sq_blocks change
    c = cyc;
    push(EV_LOAD, c + 1, ld(1, 168)); push(EV_R0, c + 2, 3); push(EV_R23, c + 25, 3);
    push(EV_OUT, c + 26, 168); push(EV_R0, c + 27, 3); push(EV_R23, c + 50, 3);
    push(EV_OUT, c + 53, 168); push(EV_R0, c + 54, 3); push(EV_R23, c + 77, 3);
    push(EV_OUT, c + 78, 168); push(EV_DONE, c + 79, 0);
    exp_rounds += 72;
    cmode = 3'd4; sq_blocks = 8'd3; first = 1'b1; last_i = 1'b1;
    buff_full = 1'b1; dout_ready = 1'b0;
    go(c + 1); last_i = 1'b0;
    go(c + 26); dout_ready = 1'b1;
    go(c + 27); dout_ready = 1'b0;
    go(c + 30); dout_ready = 1'b1;
    go(c + 31); dout_ready = 1'b0;
    go(c + 40); sq_blocks = 8'd0;
    go(c + 52);
    chk("t2_stall_valid", int'(dout_valid), 1);
    go(c + 53); dout_ready = 1'b1;
    go(c + 80);
    chk("t2_release_en_counter", int'(en_counter), 0);
    buff_full = 1'b0;
    go(c + 82);

    // SHA3-512 two blocks, last_i during the second
    c = cyc;
    push(EV_LOAD, c + 1, ld(1, 72)); push(EV_R0, c + 2, 3); push(EV_R23, c + 25, 3);
    exp_rounds += 24;
    cmode = 3'd3; first = 1'b1; last_i = 1'b0; buff_full = 1'b1; dout_ready = 1'b1;
    go(c + 26);
    chk("t3_release_valid", int'(dout_valid), 0);
    chk("t3_release_en_counter", int'(en_counter), 0);
    chk("t3_release_busy", int'(busy), 1);
    buff_full = 1'b0;
    go(c + 27);
    c2 = c + 27;
    push(EV_LOAD, c2 + 1, ld(0, 72)); push(EV_R0, c2 + 2, 3); push(EV_R23, c2 + 25, 3);
    push(EV_OUT, c2 + 26, 72); push(EV_DONE, c2 + 27, 0);
    exp_rounds += 24;
    buff_full = 1'b1; first = 1'b0; last_i = 1'b1;
    go(c2 + 1); last_i = 1'b0;
    go(c2 + 28); buff_full = 1'b0;
    go(c2 + 30);

    // illegal mode
    c = cyc;
    push(EV_ERR, c + 1, 0);
    cmode = 3'd6; first = 1'b1; buff_full = 1'b1;
    go(c + 1);
    chk("t4_rate_not_latched", int'(rate_bytes), 72);
    chk("t4_busy", int'(busy), 1);
    buff_full = 1'b0;
    go(c + 2);
    chk("t4_idle_busy", int'(busy), 0);
    go(c + 3);

    // SHAKE256 with sq_blocks=0 behaves as one block
    c = cyc;
    push(EV_LOAD, c + 1, ld(1, 136)); push(EV_R0, c + 2, 3);
    push(EV_R23, c + 25, 3); push(EV_OUT, c + 26, 136); push(EV_DONE, c + 27, 0);
    exp_rounds += 24;
    cmode = 3'd5; sq_blocks = 8'd0; first = 1'b1; last_i = 1'b1;
    buff_full = 1'b1; dout_ready = 1'b1;
    go(c + 1); last_i = 1'b0;
    go(c + 28); buff_full = 1'b0;
    go(c + 30);

    // reset mid-permutation, then pending_last must be gone
    c = cyc;
    push(EV_LOAD, c + 1, ld(1, 104)); push(EV_R0, c + 2, 3);
    exp_rounds += 11;
    cmode = 3'd2; first = 1'b1; last_i = 1'b1; buff_full = 1'b1;
    go(c + 1); last_i = 1'b0;
    go(c + 12);
    chk("t6_round_idx", int'(round_idx), 10);
    rst = 1'b1;
    go(c + 13);
    chk("t6_reset_outputs", outs(), 0);
    chk("t6_reset_rate", int'(rate_bytes), 144);
    rst = 1'b0; buff_full = 1'b0;
    go(c + 14);
    c2 = c + 14;
    push(EV_LOAD, c2 + 1, ld(1, 136)); push(EV_R0, c2 + 2, 3); push(EV_R23, c2 + 25, 3);
    exp_rounds += 24;
    cmode = 3'd1; first = 1'b1; last_i = 1'b0; buff_full = 1'b1;
    go(c2 + 26);
    chk("t6_no_squeeze", int'(dout_valid), 0);
    chk("t6_release_en_counter", int'(en_counter), 0);
    buff_full = 1'b0;
    go(c2 + 30);

    chk("events_outstanding", q.size(), 0);
    chk("round_cycles", round_seen, exp_rounds);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
